// File: rtl/noc_credit_link.sv
// rtl/noc_credit_link.sv - pipelined credit-based NoC link with credit tracker, framing monitor and sticky errors
// Optional flit/packet statistics counters are built when NOC_LINK_STATS_EN is defined.
module noc_credit_link #(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 4,
    parameter int NUM_PIPELINE      = 2,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                                   clk_noc,
    input  logic                                   rst_noc,
    input  logic [FLIT_WIDTH-1:0]                  data_in,
    input  logic [DEST_WIDTH-1:0]                  dest_in,
    input  logic                                   is_tail_in,
    input  logic                                   send_in,
    output logic                                   credit_out,
    output logic [FLIT_WIDTH-1:0]                  data_out,
    output logic [DEST_WIDTH-1:0]                  dest_out,
    output logic                                   is_tail_out,
    output logic                                   send_out,
    input  logic                                   credit_in,
    input  logic                                   err_clear,
    output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] credits_avail,
    output logic                                   err_send_no_credit,
    output logic                                   err_credit_overflow,
    output logic                                   err_framing,
    output logic [CNT_WIDTH-1:0]                   flit_count,
    output logic [CNT_WIDTH-1:0]                   pkt_count
);

    localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CW-1:0] FBD = CW'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_t;

    generate
        if (NUM_PIPELINE == 0) begin : g_bypass
            assign data_out    = data_in;
            assign dest_out    = dest_in;
            assign is_tail_out = is_tail_in;
            assign send_out    = send_in;
            assign credit_out  = credit_in;
        end else begin : g_pipe
            logic [NUM_PIPELINE-1:0] send_q;
            logic [NUM_PIPELINE-1:0] tail_q;
            logic [NUM_PIPELINE-1:0] credit_q;
            logic [FLIT_WIDTH-1:0]   data_q [NUM_PIPELINE];
            logic [DEST_WIDTH-1:0]   dest_q [NUM_PIPELINE];

            // Payload stages only move alongside a valid flit, so idle cycles cost no data toggling.
            always_ff @(posedge clk_noc or posedge rst_noc) begin
                if (rst_noc) begin
                    send_q   <= '0;
                    tail_q   <= '0;
                    credit_q <= '0;
                    for (int i = 0; i < NUM_PIPELINE; i++) begin
                        data_q[i] <= '0;
                        dest_q[i] <= '0;
                    end
                end else begin
                    send_q[0]   <= send_in;
                    credit_q[0] <= credit_in;
                    if (send_in) begin
                        data_q[0] <= data_in;
                        dest_q[0] <= dest_in;
                        tail_q[0] <= is_tail_in;
                    end
                    for (int i = 1; i < NUM_PIPELINE; i++) begin
                        send_q[i]   <= send_q[i-1];
                        credit_q[i] <= credit_q[i-1];
                        if (send_q[i-1]) begin
                            data_q[i] <= data_q[i-1];
                            dest_q[i] <= dest_q[i-1];
                            tail_q[i] <= tail_q[i-1];
                        end
                    end
                end
            end

            assign data_out    = data_q[NUM_PIPELINE-1];
            assign dest_out    = dest_q[NUM_PIPELINE-1];
            assign is_tail_out = tail_q[NUM_PIPELINE-1];
            assign send_out    = send_q[NUM_PIPELINE-1];
            assign credit_out  = credit_q[NUM_PIPELINE-1];
        end
    endgenerate

    // Credits are counted against the delayed return, i.e. as the upstream router sees them.
    logic [CW-1:0] credit_cnt;
    logic          snc_set;
    logic          ovf_set;

    assign snc_set = send_in && (credit_cnt == '0);
    assign ovf_set = credit_out && (credit_cnt == FBD);

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            credit_cnt <= FBD;
        end else begin
            case ({send_in, credit_out})
                2'b10:   if (credit_cnt != '0)  credit_cnt <= credit_cnt - CW'(1);
                2'b01:   if (credit_cnt != FBD) credit_cnt <= credit_cnt + CW'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    assign credits_avail = credit_cnt;

    frame_state_t          state;
    frame_state_t          state_next;
    logic [DEST_WIDTH-1:0] pkt_dest;
    logic                  capture_dest;
    logic                  framing_set;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state    <= IDLE;
            pkt_dest <= '0;
        end else begin
            state <= state_next;
            if (capture_dest) pkt_dest <= dest_in;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (send_in && !is_tail_in) state_next = IN_PKT;
            IN_PKT:  if (send_in && is_tail_in)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture_dest = (state == IDLE) && send_in && !is_tail_in;
        framing_set  = (state == IN_PKT) && send_in && (dest_in != pkt_dest);
    end

    // A new error in the same cycle as err_clear must survive the clear.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            err_send_no_credit  <= 1'b0;
            err_credit_overflow <= 1'b0;
            err_framing         <= 1'b0;
        end else begin
            err_send_no_credit  <= snc_set     | (err_send_no_credit  & ~err_clear);
            err_credit_overflow <= ovf_set     | (err_credit_overflow & ~err_clear);
            err_framing         <= framing_set | (err_framing         & ~err_clear);
        end
    end

`ifdef NOC_LINK_STATS_EN
    logic [CNT_WIDTH-1:0] flit_cnt_q;
    logic [CNT_WIDTH-1:0] pkt_cnt_q;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else if (send_in) begin
            flit_cnt_q <= flit_cnt_q + CNT_WIDTH'(1);
            if (is_tail_in) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign flit_count = flit_cnt_q;
    assign pkt_count  = pkt_cnt_q;
`else
    assign flit_count = '0;
    assign pkt_count  = '0;
`endif

endmodule
